// File: rtl/cnt_disp_drv_if.sv
// Bus between the binary counter stage and the seven-segment display driver.
// The master side drives the count; the slave side (the driver) produces the display lines.
interface cnt_disp_drv_if #(
  parameter int N = 8
);
  logic [N-1:0] bin_in;
  logic         upd;
  logic [3:0]   sel;
  logic [7:0]   seg;

  modport master (output bin_in, input upd, input sel, input seg);
  modport slave  (input bin_in, output upd, output sel, output seg);
endinterface

// File: rtl/cnt_disp_drv.sv
// Sequential double-dabble BCD converter feeding a 4-digit multiplexed common-anode display.
// Optional feature macro: LEAD_ZERO_BLANK_EN (blank leading zero digits, units always shown).
module cnt_disp_drv #(
  parameter int N        = 8,
  parameter int SCAN_DIV = 50000
) (
  input logic           sys_clk,
  input logic           sys_rst_n,
  cnt_disp_drv_if.slave bus
);
  localparam int KW = (N < 2) ? 1 : $clog2(N);
  localparam int DW = $clog2(SCAN_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] r;
    case (d)
      4'd0:    r = 8'hC0;
      4'd1:    r = 8'hF9;
      4'd2:    r = 8'hA4;
      4'd3:    r = 8'hB0;
      4'd4:    r = 8'h99;
      4'd5:    r = 8'h92;
      4'd6:    r = 8'h82;
      4'd7:    r = 8'hF8;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h90;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  logic [1:0]    state_r;
  logic [KW-1:0] k_r;
  logic [N-1:0]  bin_r;
  logic [15:0]   bcd_r;
  logic [15:0]   disp_bcd_r;
  logic [DW-1:0] div_cnt_r;
  logic [1:0]    dig_idx_r;
  logic          upd_r;
  logic [3:0]    sel_r;
  logic [7:0]    seg_r;

  logic [15:0]   corr_s;
  logic [15+N:0] shifted_s;
  logic [3:0]    nib_s;
  logic          blank_s;

  // Per-nibble add-3 correction, then one left shift of the combined {bcd, bin} register
  always_comb begin
    corr_s    = {add3(bcd_r[15:12]), add3(bcd_r[11:8]), add3(bcd_r[7:4]), add3(bcd_r[3:0])};
    shifted_s = {corr_s, bin_r} << 1;
  end

  // Select the displayed nibble and decide whether it is a blanked leading zero
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    case (dig_idx_r)
      2'd0:    nib_s = disp_bcd_r[3:0];
      2'd1:    nib_s = disp_bcd_r[7:4];
      2'd2:    nib_s = disp_bcd_r[11:8];
      2'd3:    nib_s = disp_bcd_r[15:12];
      default: nib_s = 4'd0;
    endcase
`ifdef LEAD_ZERO_BLANK_EN
    case (dig_idx_r)
      2'd1:    blank_s = (disp_bcd_r[15:4] == 12'd0);
      2'd2:    blank_s = (disp_bcd_r[15:8] == 8'd0);
      2'd3:    blank_s = (disp_bcd_r[15:12] == 4'd0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
  end

  // Converter FSM: sample in IDLE, N correction+shift steps, then latch the result
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_r    <= ST_IDLE;
      k_r        <= '0;
      bin_r      <= '0;
      bcd_r      <= 16'd0;
      disp_bcd_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bin_r   <= bus.bin_in;
          bcd_r   <= 16'd0;
          k_r     <= '0;
          state_r <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_r <= shifted_s[15+N:N];
          bin_r <= shifted_s[N-1:0];
          k_r   <= k_r + KW'(1);
          if (k_r == KW'(N - 1)) begin
            state_r <= ST_LATCH;
          end
        end
        ST_LATCH: begin
          disp_bcd_r <= bcd_r;
          state_r    <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Free-running scan divider stepping through the four digits
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_cnt_r <= '0;
      dig_idx_r <= 2'd0;
    end else if (div_cnt_r == DW'(SCAN_DIV - 1)) begin
      div_cnt_r <= '0;
      dig_idx_r <= dig_idx_r + 2'd1;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

  // Output stage: sel and seg share one register so they always switch together
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      upd_r <= 1'b0;
      sel_r <= 4'hF;
      seg_r <= 8'hFF;
    end else begin
      upd_r <= (state_r == ST_LATCH);
      sel_r <= ~(4'b0001 << dig_idx_r);
      seg_r <= blank_s ? 8'hFF : seg_decode(nib_s);
    end
  end

  assign bus.upd = upd_r;
  assign bus.sel = sel_r;
  assign bus.seg = seg_r;
endmodule

// File: tb/tb_cnt_disp_drv.sv
// Self-checking bench for cnt_disp_drv (N=13, SCAN_DIV=4): an arithmetic reference model
// checked every cycle, plus directed scenarios with hand-computed display patterns.
module tb_cnt_disp_drv;
  localparam int N  = 13;
  localparam int SD = 4;
  localparam logic [7:0] SEG_TBL [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                          8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic sys_clk;
  logic sys_rst_n;
  cnt_disp_drv_if #(.N(N)) bus ();

  cnt_disp_drv #(.N(N), .SCAN_DIV(SD)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_to(input string nm, input bit expired);
    n_checks++;
    if (expired) begin
      n_fail++;
      $display("FAIL %s: wait bound expired, got timeout expected event at %0t", nm, $time);
    end
  endtask

  // Reference model: value shown is the decimal digit of the last latched count
  function automatic logic [7:0] model_seg(input int unsigned v, input int d);
    int unsigned p;
    p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    if (LZB && d > 0 && v < p) return 8'hFF;
    return SEG_TBL[(v / p) % 10];
  endfunction

  int          e_m;
  int unsigned samp_m;
  int unsigned disp_m;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_upd;
  bit          model_valid = 1'b0;

  // Edge-count model: sample every N+2 edges, latch N+1 edges later, digit = (edge/SD) mod 4
  always @(posedge sys_clk) begin
    int d;
    int ph;
    if (!sys_rst_n) begin
      e_m = 0; disp_m = 0; samp_m = 0;
      exp_sel = 4'hF; exp_seg = 8'hFF; exp_upd = 1'b0;
      model_valid = 1'b1;
    end else begin
      e_m = e_m + 1;
      d = ((e_m - 1) / SD) % 4;
      ph = (e_m - 1) % (N + 2);
      exp_sel = ~(4'b0001 << d);
      exp_seg = model_seg(disp_m, d);
      exp_upd = (ph == N + 1);
      if (ph == 0) samp_m = bus.bin_in;
      if (ph == N + 1) disp_m = samp_m;
    end
  end

  always @(negedge sys_clk) begin
    if (model_valid) begin
      check_val("model_sel", {28'd0, bus.sel}, {28'd0, exp_sel});
      check_val("model_seg", {24'd0, bus.seg}, {24'd0, exp_seg});
      check_val("model_upd", {31'd0, bus.upd}, {31'd0, exp_upd});
    end
  end

  task automatic wait_upd(output int cnt);
    cnt = 0;
    do begin
      @(negedge sys_clk);
      cnt++;
    end while (bus.upd !== 1'b1 && cnt < 40);
    check_to("upd_wait", bus.upd !== 1'b1);
  endtask

  task automatic check_digit(input string nm, input logic [3:0] sel_w, input logic [7:0] seg_w);
    int n;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (bus.sel !== sel_w && n < 15);
    check_to({nm, "_sel_wait"}, bus.sel !== sel_w);
    check_val(nm, {24'd0, bus.seg}, {24'd0, seg_w});
  endtask

  task automatic frame_check(input string nm, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
    logic [7:0] segs [4];
    logic [3:0] sels [4];
    logic [3:0] prev;
    int n;
    segs = '{s0, s1, s2, s3};
    sels = '{4'hE, 4'hD, 4'hB, 4'h7};
    prev = bus.sel;
    n = 0;
    @(negedge sys_clk);
    while (!(bus.sel === 4'hE && prev !== 4'hE) && n < 40) begin
      prev = bus.sel;
      @(negedge sys_clk);
      n++;
    end
    check_to({nm, "_sync"}, n >= 40);
    for (int i = 0; i < 16; i++) begin
      check_val({nm, "_sel"}, {28'd0, bus.sel}, {28'd0, sels[i / 4]});
      check_val({nm, "_seg"}, {24'd0, bus.seg}, {24'd0, segs[i / 4]});
      @(negedge sys_clk);
    end
    check_val({nm, "_wrap_sel"}, {28'd0, bus.sel}, 32'hE);
  endtask

  initial begin
    int cnt;
    sys_rst_n  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge sys_clk);
    check_val("rst_sel", {28'd0, bus.sel}, 32'hF);
    check_val("rst_seg", {24'd0, bus.seg}, 32'hFF);
    check_val("rst_upd", {31'd0, bus.upd}, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_val("first_sel", {28'd0, bus.sel}, 32'hE);
    check_val("first_seg", {24'd0, bus.seg}, 32'hC0);
    wait_upd(cnt);
    check_val("first_upd_delay", cnt, 32'd14);

    // 1234: units..thousands = 4,3,2,1
    bus.bin_in = 13'd1234;
    wait_upd(cnt);
    frame_check("f1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);

    // 8191 exercises corrections on nibbles 5..9
    wait_upd(cnt);
    bus.bin_in = 13'd8191;
    wait_upd(cnt);
    frame_check("f8191", 8'hF9, 8'h90, 8'hF9, 8'h80);

    // Change after the IDLE sample must not affect the running conversion
    wait_upd(cnt);
    bus.bin_in = 13'd100;
    repeat (2) @(negedge sys_clk);
    bus.bin_in = 13'd200;
    wait_upd(cnt);
    check_val("late_change_upd_gap", cnt, 32'd13);
    check_digit("hund_100", 4'hB, 8'hF9);
    wait_upd(cnt);
    wait_upd(cnt);
    check_digit("hund_200", 4'hB, 8'hA4);

    // Reset in the middle of SHIFT discards the partial result
    wait_upd(cnt);
    bus.bin_in = 13'd4321;
    repeat (5) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check_val("midrst_sel", {28'd0, bus.sel}, 32'hF);
    check_val("midrst_seg", {24'd0, bus.seg}, 32'hFF);
    check_val("midrst_upd", {31'd0, bus.upd}, 32'h0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check_val("midrst_first_seg", {24'd0, bus.seg}, 32'hC0);
    wait_upd(cnt);
    check_val("midrst_upd_delay", cnt, 32'd14);
    check_digit("thou_4321", 4'h7, 8'h99);
    wait_upd(cnt);
    check_digit("unit_4321", 4'hE, 8'hF9);

    // Single digit value: leading digits blank or zero depending on build
    bus.bin_in = 13'd5;
    wait_upd(cnt);
    wait_upd(cnt);
    frame_check("f5", 8'h92, LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0, LZB ? 8'hFF : 8'hC0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cnt_disp_drv.md
# cnt_disp_drv

Display driver that sits directly downstream of the binary counter and turns its N-bit count into a scanned 4-digit common-anode seven-segment display. A sequential double-dabble converter samples the count and converts it to BCD. The result is latched into a display register. A free-running scan divider then time-multiplexes the four digits onto shared segment lines.

## Interface
- N, 8: width of bin_in; legal range 1..13, so the maximum input 8191 fits in 4 BCD digits.
- SCAN_DIV, 50000: sys_clk cycles each digit stays selected; legal range ≥2.
- sys_clk  input  1  sole clock; all state updates on the rising edge.
- sys_rst_n  input  1  reset, synchronous and active-low.
- bin_in  input  N  binary count from the counter stage; sampled only in IDLE.
- upd  output  1  one-cycle pulse when the display register takes a new value.
- sel  output  4  digit enables, active-low, one-hot; sel[0] = units … sel[3] = thousands.
- seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

## Operation
- Converter FSM states: IDLE, SHIFT, LATCH.
  - IDLE: load bin_in into the shift register, clear the 16-bit BCD accumulator, clear bit counter k, go to SHIFT.
  - SHIFT: for each BCD nibble ≥5, add 3. Then shift {bcd, bin} left by 1. Increment k. After the N-th shift, go to LATCH.
  - LATCH: copy bcd to disp_bcd, assert upd, go to IDLE.
- The converter runs continuously. Changes on bin_in outside the IDLE cycle are ignored until the next IDLE.
- BCD arithmetic: each nibble's add-3 correction stays within 4 bits. No carry crosses a nibble during correction.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - At div_cnt = SCAN_DIV-1, dig_idx increments 0→1→2→3→0.
- Output register, updated every cycle:
  - sel = ~(4'b0001 << dig_idx).
  - seg = decode(disp_bcd nibble dig_idx).
- Decode, hex, dp always off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Blank = FF.
- Any nibble value 10..15 decodes to blank. This is unreachable in legal use.

## Timing
- Reset (sys_rst_n low at an edge):
  - FSM → IDLE.
  - k, bcd, disp_bcd, div_cnt, dig_idx = 0.
  - upd = 0, sel = 4'hF, seg = 8'hFF.
- First edge after reset release: sel = 4'b1110, seg = 8'hC0.
- Conversion period: N+2 cycles.
  - bin_in is sampled at the IDLE edge.
  - disp_bcd and upd change at the LATCH edge, N+1 edges later.
  - seg reflects the new value one edge after that, when the selected digit is the one that changed.
- upd is high for exactly 1 cycle per conversion, every N+2 cycles.
- seg/sel lag dig_idx/disp_bcd by exactly one register stage. sel and seg always change on the same edge, so no mismatched digit/segment cycle occurs.
- Reset mid-conversion:
  - The partial BCD is discarded and disp_bcd is cleared to 0.
  - The next conversion starts on the first edge with sys_rst_n high.
- dig_idx wrap 3→0 is seamless. Each digit is enabled exactly SCAN_DIV cycles per 4·SCAN_DIV frame.

## Configuration
- Macro: LEAD_ZERO_BLANK_EN.
- Defined: leading-zero blanking is enabled.
  - A thousands/hundreds/tens digit shows blank (seg = FF) when it and every higher digit are 0.
  - sel scanning is unchanged.
  - The units digit is never blanked, so 0 displays as "   0".
  - The blank decision uses disp_bcd and is registered with seg.
- Undefined: all four digits always display, including leading zeros (0 displays as "0000").

## Test plan
Bench uses N=13, SCAN_DIV=4.
- Reset hold 3 cycles, then release with bin_in=0 -> during reset sel=F, seg=FF, upd=0; first post-reset edge sel=E, seg=C0; upd first pulses 14 cycles after release.
- bin_in=1234 held -> after upd, one full frame shows seg sequence 99(4), B0(3), A4(2), F9(1) with sel E, D, B, 7, each held 4 cycles; then sel returns to E.
- bin_in=8191 -> digits 1,9,1,8 (units→thousands); the 9 is checked for an add-3 correction on a nibble equal to 5..9.
- bin_in changes 100→200 two cycles after the IDLE sample -> the next upd shows 100; the following upd shows 200.
- sys_rst_n pulsed low during SHIFT with bin_in=4321 -> disp_bcd=0 and seg=FF/sel=F on the reset edge; 4321 appears after the next full N+2-cycle conversion.
- bin_in=5 with LEAD_ZERO_BLANK_EN defined -> thousands/hundreds/tens seg=FF, units seg=92. Without the macro -> C0, C0, C0, 92.
